// File: rtl/param_pipe_barrel_shifter_if.sv
// Handshake bundle for the pipelined barrel shifter: producer side (in_*) and consumer side (out_*).
// The shifter drives through the slave modport; the producer/consumer pair drives through master.
interface param_pipe_barrel_shifter_if #(
    parameter int N = 3
);
    localparam int W = 1 << N;

    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_data;
    logic [N-1:0] in_amt;
    logic [1:0]   in_mode;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_data;

    modport master (
        output in_valid, in_data, in_amt, in_mode, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, in_amt, in_mode, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/param_pipe_barrel_shifter.sv
// Purpose: pipelined ROR/ROL/LSR/ASR on a 2**N-bit word, one registered log2 stage per amt bit.
// Latency: N cycles from acceptance to out_valid; 1 word/clock throughput.
// Backpressure: whole pipe freezes when out_valid && !out_ready; in_ready is that advance term.
module param_pipe_barrel_shifter #(
    parameter int N = 3
) (
    input  logic                          clk,
    input  logic                          reset_n,
    param_pipe_barrel_shifter_if.slave    bus
);
    localparam int W = 1 << N;

    localparam logic [1:0] MODE_ROR = 2'b00;
    localparam logic [1:0] MODE_ROL = 2'b01;
    localparam logic [1:0] MODE_LSR = 2'b10;
    localparam logic [1:0] MODE_ASR = 2'b11;

    logic [N-1:0] vld_q,  vld_d;
    logic [W-1:0] dat_q  [N];
    logic [W-1:0] dat_d  [N];
    logic [N-1:0] amt_q  [N];
    logic [N-1:0] amt_d  [N];
    logic [1:0]   mode_q [N];
    logic [1:0]   mode_d [N];
    logic [N-1:0] fill_q, fill_d;
    logic         advance;

    // Move by a fixed power-of-two distance; ROL moves left directly rather than remapping to ROR.
    function automatic logic [W-1:0] move(input logic [W-1:0] d, input logic [1:0] mode,
                                          input logic fill, input int s);
        logic [W-1:0] r;
        logic [W-1:0] ones;
        ones = '1;
        case (mode)
            MODE_ROR: r = (d >> s) | (d << (W - s));
            MODE_ROL: r = (d << s) | (d >> (W - s));
            MODE_LSR: r = d >> s;
            MODE_ASR: r = (d >> s) | ({W{fill}} & ~(ones >> s));
            default:  r = d;
        endcase
        return r;
    endfunction

    always_comb begin
        logic         src_vld;
        logic [W-1:0] src_dat;
        logic [N-1:0] src_amt;
        logic [1:0]   src_mode;
        logic         src_fill;

        src_vld  = 1'b0;
        src_dat  = '0;
        src_amt  = '0;
        src_mode = '0;
        src_fill = 1'b0;
        vld_d    = '0;
        fill_d   = '0;
        dat_d    = '{default: '0};
        amt_d    = '{default: '0};
        mode_d   = '{default: '0};

        advance = !vld_q[N-1] || bus.out_ready;

        for (int k = 0; k < N; k++) begin
            // The ASR sign is latched on entry so later stages never look at the shifted word's MSB.
            if (k == 0) begin
                src_vld  = bus.in_valid;
                src_dat  = bus.in_data;
                src_amt  = bus.in_amt;
                src_mode = bus.in_mode;
                src_fill = bus.in_data[W-1];
            end else begin
                src_vld  = vld_q[k-1];
                src_dat  = dat_q[k-1];
                src_amt  = amt_q[k-1];
                src_mode = mode_q[k-1];
                src_fill = fill_q[k-1];
            end

            vld_d[k]  = src_vld;
            dat_d[k]  = src_amt[k] ? move(src_dat, src_mode, src_fill, 1 << k) : src_dat;
            amt_d[k]  = src_amt;
            mode_d[k] = src_mode;
            fill_d[k] = src_fill;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vld_q  <= '0;
            fill_q <= '0;
            dat_q  <= '{default: '0};
            amt_q  <= '{default: '0};
            mode_q <= '{default: '0};
        end else if (advance) begin
            vld_q  <= vld_d;
            fill_q <= fill_d;
            dat_q  <= dat_d;
            amt_q  <= amt_d;
            mode_q <= mode_d;
        end
    end

    assign bus.in_ready  = advance;
    assign bus.out_valid = vld_q[N-1];
    assign bus.out_data  = dat_q[N-1];
endmodule

// File: tb/tb_param_pipe_barrel_shifter.sv
module tb_param_pipe_barrel_shifter;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    param_pipe_barrel_shifter_if #(.N(3)) bus ();
    param_pipe_barrel_shifter_if #(.N(5)) bus5 ();

    param_pipe_barrel_shifter #(.N(3)) dut  (.clk(clk), .reset_n(reset_n), .bus(bus));
    param_pipe_barrel_shifter #(.N(5)) dut5 (.clk(clk), .reset_n(reset_n), .bus(bus5));

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [7:0]  exp_q[$];
    logic [7:0]  got_q[$];
    int          acc_cyc[$];
    int          got_cyc[$];
    bit          ov_h[$];
    bit          ir_h[$];
    logic [31:0] exp5_q[$];
    logic [31:0] got5_q[$];

    // Bitwise reference: output bit i names which input bit (or fill) lands there.
    function automatic logic [31:0] model(input int w, input logic [31:0] d, input int a,
                                          input logic [1:0] m);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < w; i++) begin
            case (m)
                2'b00: r[i] = d[(i + a) % w];
                2'b01: r[i] = d[(i - a + w) % w];
                2'b10: r[i] = (i + a < w) ? d[i + a] : 1'b0;
                default: r[i] = (i + a < w) ? d[i + a] : d[w - 1];
            endcase
        end
        return r;
    endfunction

    task automatic step();
        logic [31:0] m;
        @(negedge clk);
        if (bus.in_valid && bus.in_ready) begin
            m = model(8, {24'd0, bus.in_data}, int'(bus.in_amt), bus.in_mode);
            exp_q.push_back(m[7:0]);
            acc_cyc.push_back(cyc);
        end
        if (bus.out_valid && bus.out_ready) begin
            got_q.push_back(bus.out_data);
            got_cyc.push_back(cyc);
        end
        if (bus5.in_valid && bus5.in_ready)
            exp5_q.push_back(model(32, bus5.in_data, int'(bus5.in_amt), bus5.in_mode));
        if (bus5.out_valid && bus5.out_ready)
            got5_q.push_back(bus5.out_data);
        ov_h.push_back(bus.out_valid);
        ir_h.push_back(bus.in_ready);
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic clear_sb();
        exp_q.delete(); got_q.delete(); acc_cyc.delete(); got_cyc.delete();
        ov_h.delete(); ir_h.delete(); exp5_q.delete(); got5_q.delete();
        cyc = 0;
    endtask

    task automatic drive(input bit v, input logic [7:0] d, input logic [2:0] a, input logic [1:0] m);
        bus.in_valid = v;
        bus.in_data  = d;
        bus.in_amt   = a;
        bus.in_mode  = m;
    endtask

    task automatic idle();
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        bus5.in_valid  = 1'b0;
        bus5.out_ready = 1'b1;
    endtask

    task automatic drain();
        idle();
        for (int i = 0; i < 60 && (got_q.size() < exp_q.size() || got5_q.size() < exp5_q.size()); i++)
            step();
        repeat (4) step();
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.out_data !== 8'h00) begin
            errors++;
            $display("FAIL reset_held: out_valid=%b out_data=%h want 0/00", bus.out_valid, bus.out_data);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.out_data !== 8'h00) begin
            errors++;
            $display("FAIL reset_release: in_ready=%b out_valid=%b out_data=%h want 1/0/00",
                     bus.in_ready, bus.out_valid, bus.out_data);
        end
    endtask

    task automatic test_modes();
        logic [7:0] d [5] = '{8'h96, 8'h96, 8'h96, 8'h96, 8'h16};
        logic [2:0] a [5] = '{3'd1, 3'd3, 3'd2, 3'd2, 3'd2};
        logic [1:0] m [5] = '{2'b00, 2'b01, 2'b10, 2'b11, 2'b11};
        logic [7:0] r [5] = '{8'h4B, 8'hB4, 8'h25, 8'hE5, 8'h05};
        clear_sb();
        idle();
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, d[i], a[i], m[i]);
            step();
        end
        drain();
        checks++;
        if (got_q.size() != 5) begin
            errors++;
            $display("FAIL modes_count: got %0d words want 5", got_q.size());
        end
        for (int i = 0; i < 5 && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== r[i]) begin
                errors++;
                $display("FAIL modes_data[%0d]: got %h want %h", i, got_q[i], r[i]);
            end
            checks++;
            if (got_cyc[i] - acc_cyc[i] != 3) begin
                errors++;
                $display("FAIL modes_latency[%0d]: got %0d want 3", i, got_cyc[i] - acc_cyc[i]);
            end
        end
    endtask

    task automatic test_identity();
        logic [7:0] d [7] = '{8'hA5, 8'hA5, 8'hA5, 8'hA5, 8'h01, 8'h80, 8'h80};
        logic [2:0] a [7] = '{3'd0, 3'd0, 3'd0, 3'd0, 3'd7, 3'd7, 3'd7};
        logic [1:0] m [7] = '{2'b00, 2'b01, 2'b10, 2'b11, 2'b00, 2'b10, 2'b11};
        logic [7:0] r [7] = '{8'hA5, 8'hA5, 8'hA5, 8'hA5, 8'h02, 8'h01, 8'hFF};
        clear_sb();
        idle();
        for (int i = 0; i < 7; i++) begin
            drive(1'b1, d[i], a[i], m[i]);
            step();
        end
        drain();
        checks++;
        if (got_q.size() != 7) begin
            errors++;
            $display("FAIL extremes_count: got %0d words want 7", got_q.size());
        end
        for (int i = 0; i < 7 && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== r[i]) begin
                errors++;
                $display("FAIL extremes_data[%0d]: got %h want %h", i, got_q[i], r[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        int lows;
        clear_sb();
        idle();
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 8'($urandom), 3'($urandom), 2'($urandom));
            step();
        end
        lows = 0;
        foreach (ir_h[i]) if (!ir_h[i]) lows++;
        drain();
        checks++;
        if (lows != 0) begin
            errors++;
            $display("FAIL stream_in_ready: low for %0d cycles want 0", lows);
        end
        checks++;
        if (got_q.size() != 8) begin
            errors++;
            $display("FAIL stream_count: got %0d words want 8", got_q.size());
        end
        for (int i = 0; i < 8 && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i] || got_cyc[i] != got_cyc[0] + i) begin
                errors++;
                $display("FAIL stream_word[%0d]: got %h at cycle %0d want %h at cycle %0d",
                         i, got_q[i], got_cyc[i], exp_q[i], got_cyc[0] + i);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [7:0] held;
        clear_sb();
        idle();
        bus.out_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (!bus.in_ready) break;
            drive(1'b1, 8'($urandom), 3'($urandom), 2'($urandom));
            step();
        end
        held = bus.out_data;
        checks++;
        if (exp_q.size() != 3 || held !== exp_q[0]) begin
            errors++;
            $display("FAIL bp_fill: accepted %0d out_data=%h want 3 words, head %h",
                     exp_q.size(), held, (exp_q.size() > 0) ? exp_q[0] : 8'h00);
        end
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 8'($urandom), 3'($urandom), 2'($urandom));
            step();
            checks++;
            if (bus.in_ready !== 1'b0 || bus.out_data !== held || bus.out_valid !== 1'b1) begin
                errors++;
                $display("FAIL bp_hold[%0d]: in_ready=%b out_valid=%b out_data=%h want 0/1/%h",
                         i, bus.in_ready, bus.out_valid, bus.out_data, held);
            end
        end
        drain();
        checks++;
        if (got_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL bp_count: got %0d words want %0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL bp_data[%0d]: got %h want %h", i, got_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_bubbles();
        bit pat [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        clear_sb();
        idle();
        for (int i = 0; i < 5; i++) begin
            drive(pat[i], 8'($urandom), 3'($urandom), 2'($urandom));
            step();
        end
        drain();
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (ov_h[i + 3] !== pat[i]) begin
                errors++;
                $display("FAIL bubble_valid[%0d]: out_valid=%b want %b", i, ov_h[i + 3], pat[i]);
            end
        end
        checks++;
        if (got_q != exp_q) begin
            errors++;
            $display("FAIL bubble_data: got %0d words want %0d", got_q.size(), exp_q.size());
        end
    endtask

    task automatic test_reset_mid();
        int lows;
        clear_sb();
        idle();
        bus.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 8'($urandom_range(255, 1)), 3'($urandom), 2'($urandom));
            step();
        end
        drive(1'b0, 8'h00, 3'd0, 2'b00);
        #2;
        reset_n = 1'b0;
        #1;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.out_data !== 8'h00 || bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL midreset_now: out_valid=%b out_data=%h in_ready=%b want 0/00/1",
                     bus.out_valid, bus.out_data, bus.in_ready);
        end
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        clear_sb();
        idle();
        repeat (8) step();
        lows = 0;
        foreach (ir_h[i]) if (!ir_h[i]) lows++;
        checks++;
        if (got_q.size() != 0 || lows != 0) begin
            errors++;
            $display("FAIL midreset_stale: emerged %0d words, in_ready low %0d cycles want 0/0",
                     got_q.size(), lows);
        end
    endtask

    task automatic test_random();
        int bad;
        clear_sb();
        idle();
        for (int i = 0; i < 400; i++) begin
            drive(($urandom % 4) != 0, 8'($urandom), 3'($urandom), 2'($urandom));
            bus.out_ready = ($urandom % 3) != 0;
            step();
        end
        drain();
        checks++;
        if (got_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL random8_count: got %0d words want %0d", got_q.size(), exp_q.size());
        end
        bad = 0;
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            if (got_q[i] !== exp_q[i]) begin
                if (bad == 0)
                    $display("FAIL random8_data[%0d]: got %h want %h", i, got_q[i], exp_q[i]);
                bad++;
            end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL random8_total: %0d wrong words want 0", bad);
        end
    endtask

    task automatic test_random_wide();
        int bad;
        clear_sb();
        idle();
        for (int i = 0; i < 400; i++) begin
            bus5.in_valid  = ($urandom % 4) != 0;
            bus5.in_data   = $urandom;
            bus5.in_amt    = 5'($urandom);
            bus5.in_mode   = 2'($urandom);
            bus5.out_ready = ($urandom % 3) != 0;
            step();
        end
        drain();
        checks++;
        if (got5_q.size() != exp5_q.size()) begin
            errors++;
            $display("FAIL random32_count: got %0d words want %0d", got5_q.size(), exp5_q.size());
        end
        bad = 0;
        for (int i = 0; i < exp5_q.size() && i < got5_q.size(); i++)
            if (got5_q[i] !== exp5_q[i]) begin
                if (bad == 0)
                    $display("FAIL random32_data[%0d]: got %h want %h", i, got5_q[i], exp5_q[i]);
                bad++;
            end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL random32_total: %0d wrong words want 0", bad);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within 200000 time units");
        $fatal(1, "watchdog");
    end

    initial begin
        idle();
        drive(1'b0, 8'h00, 3'd0, 2'b00);
        bus5.in_data = '0;
        bus5.in_amt  = '0;
        bus5.in_mode = '0;
        test_reset();
        test_modes();
        test_identity();
        test_back_to_back();
        test_backpressure();
        test_bubbles();
        test_reset_mid();
        test_random();
        test_random_wide();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
